// File: rtl/edge_detect_bank_if.sv
// Bus bundle for edge_detect_bank: channel inputs, configuration and per-channel status.
// The master side drives inputs and configuration; the slave side is the detector bank.
interface edge_detect_bank_if #(
  parameter int NCH    = 8,
  parameter int FILT_W = 4
);
  logic                enable;
  logic [NCH-1:0]      signal;
  logic [2*NCH-1:0]    mode;
  logic [FILT_W-1:0]   filt_len;
  logic [NCH-1:0]      clr;
  logic [NCH-1:0]      edge_strb;
  logic [NCH-1:0]      level;
  logic [NCH-1:0]      pending;
  logic [NCH-1:0]      overrun;
  logic                any_pending;

  modport master (
    output enable, signal, mode, filt_len, clr,
    input  edge_strb, level, pending, overrun, any_pending
  );

  modport slave (
    input  enable, signal, mode, filt_len, clr,
    output edge_strb, level, pending, overrun, any_pending
  );
endinterface

// File: rtl/edge_detect_bank.sv
// Per-channel synchronizer, optional glitch filter, edge strobe and sticky pending/overrun flags.
// Define EDGE_DETECT_FILTER_EN to build the glitch filter; otherwise filt_len is ignored.
module edge_detect_bank #(
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  edge_detect_bank_if.slave  bus
);

  logic [SYNC_STAGES-1:0][NCH-1:0] sync_r;
  logic [NCH-1:0] sync_s;
  logic [NCH-1:0] level_r;
  logic [NCH-1:0] level_d_r;
  logic [NCH-1:0] strb_r;
  logic [NCH-1:0] pend_r;
  logic [NCH-1:0] ovr_r;
  logic [NCH-1:0] rise_s;
  logic [NCH-1:0] fall_s;
  logic [NCH-1:0] strb_nxt_s;

  // Synchronizer shift chain, newest sample in stage 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.signal};
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

`ifdef EDGE_DETECT_FILTER_EN
  logic [NCH-1:0][FILT_W-1:0] cnt_r;
  logic [NCH-1:0][FILT_W-1:0] cnt_nxt_s;
  logic [NCH-1:0][FILT_W:0]   inc_s;
  logic [NCH-1:0]             level_nxt_s;
  logic [FILT_W:0]            len_s;

  // Filter decision: accept a new value after len_s consecutive differing samples
  always_comb begin
    if (bus.filt_len == {FILT_W{1'b0}}) begin
      len_s = {{FILT_W{1'b0}}, 1'b1};
    end else begin
      len_s = {1'b0, bus.filt_len};
    end
    for (int i = 0; i < NCH; i++) begin
      inc_s[i]       = {1'b0, cnt_r[i]} + {{FILT_W{1'b0}}, 1'b1};
      cnt_nxt_s[i]   = {FILT_W{1'b0}};
      level_nxt_s[i] = level_r[i];
      if (sync_s[i] != level_r[i]) begin
        if (inc_s[i] >= len_s) begin
          level_nxt_s[i] = sync_s[i];
          cnt_nxt_s[i]   = {FILT_W{1'b0}};
        end else begin
          level_nxt_s[i] = level_r[i];
          cnt_nxt_s[i]   = inc_s[i][FILT_W-1:0];
        end
      end else begin
        level_nxt_s[i] = level_r[i];
        cnt_nxt_s[i]   = {FILT_W{1'b0}};
      end
    end
  end

  // Filter counters and filtered level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      level_r <= '0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      level_r <= level_nxt_s;
    end
  end
`else
  logic unused_filt_s;
  assign unused_filt_s = ^bus.filt_len;

  // Unfiltered level is the last sync stage registered once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r <= '0;
    end else begin
      level_r <= sync_s;
    end
  end
`endif

  // Event decode; level history keeps tracking while enable is low
  always_comb begin
    rise_s = level_r & ~level_d_r;
    fall_s = ~level_r & level_d_r;
    for (int i = 0; i < NCH; i++) begin
      strb_nxt_s[i] = bus.enable &
                      ((bus.mode[2*i] & rise_s[i]) | (bus.mode[2*i+1] & fall_s[i]));
    end
  end

  // Level history, strobe and sticky flags; a strobe coinciding with clr wins for pending
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d_r <= '0;
      strb_r    <= '0;
      pend_r    <= '0;
      ovr_r     <= '0;
    end else begin
      level_d_r <= level_r;
      strb_r    <= strb_nxt_s;
      pend_r    <= strb_r | (pend_r & ~bus.clr);
      ovr_r     <= (ovr_r & ~bus.clr) | (strb_r & pend_r & ~bus.clr);
    end
  end

  assign bus.edge_strb   = strb_r;
  assign bus.level       = level_r;
  assign bus.pending     = pend_r;
  assign bus.overrun     = ovr_r;
  assign bus.any_pending = |pend_r;

endmodule
